// File: rtl/gate_resp_checker.sv
// Checks (a,b,c) gate observations against TRUTH_TABLE over a run of NUM_SAMPLES samples.
// Optional GATE_RESP_CHECKER_ABORT_EN: the first mismatch ends the run at once.
module gate_resp_checker #(
  parameter logic [3:0] TRUTH_TABLE = 4'b1011,
  parameter int         NUM_SAMPLES = 4,
  parameter int         ERR_W       = 8,
  parameter int         REQUIRE_COV = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sample_valid,
  output logic             sample_ready,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [ERR_W-1:0] err_count,
  output logic [7:0]       first_err_idx,
  output logic [3:0]       seen_mask
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

`ifdef GATE_RESP_CHECKER_ABORT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif

  localparam logic [7:0]       LAST_IDX = 8'(NUM_SAMPLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  state_t           state_q, state_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic [7:0]       first_err_idx_q, first_err_idx_d;
  logic [7:0]       idx_q, idx_d;
  logic [3:0]       seen_mask_q, seen_mask_d;
  logic             pass_q, pass_d;

  logic [1:0]       ab;
  logic             accept;
  logic             mismatch;
  logic             last;

  always_comb begin
    state_d         = state_q;
    err_count_d     = err_count_q;
    first_err_idx_d = first_err_idx_q;
    idx_d           = idx_q;
    seen_mask_d     = seen_mask_q;
    pass_d          = pass_q;

    ab       = {a, b};
    accept   = (state_q == RUN) && sample_valid;
    mismatch = (c != TRUTH_TABLE[ab]);
    last     = (idx_q == LAST_IDX);

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d         = RUN;
          err_count_d     = '0;
          first_err_idx_d = '0;
          idx_d           = '0;
          seen_mask_d     = '0;
          pass_d          = 1'b0;
        end
      end
      RUN: begin
        if (accept) begin
          seen_mask_d[ab] = 1'b1;
          idx_d           = idx_q + 8'd1;
          if (mismatch) begin
            // A zero count before this sample means this is the run's first mismatch.
            if (err_count_q == '0) first_err_idx_d = idx_q;
            if (err_count_q != ERR_MAX) err_count_d = err_count_q + 1'b1;
          end
          if (last || (ABORT_EN && mismatch)) begin
            state_d = DONE;
            pass_d  = (err_count_d == '0) && ((REQUIRE_COV == 0) || (seen_mask_d == 4'hF));
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      err_count_q     <= '0;
      first_err_idx_q <= '0;
      idx_q           <= '0;
      seen_mask_q     <= '0;
      pass_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      err_count_q     <= err_count_d;
      first_err_idx_q <= first_err_idx_d;
      idx_q           <= idx_d;
      seen_mask_q     <= seen_mask_d;
      pass_q          <= pass_d;
    end
  end

  assign sample_ready  = (state_q == RUN);
  assign busy          = (state_q == RUN);
  assign done          = (state_q == DONE);
  assign pass          = done && pass_q;
  assign fail          = done && !pass_q;
  assign err_count     = err_count_q;
  assign first_err_idx = first_err_idx_q;
  assign seen_mask     = seen_mask_q;

endmodule

// File: tb/tb_gate_resp_checker.sv
// Scoreboard bench for gate_resp_checker: three instances (defaults, REQUIRE_COV=0, ERR_W=2/NUM_SAMPLES=6).
module tb_gate_resp_checker;

  localparam logic [3:0] TT = 4'b1011;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] start_v = 3'b000;
  logic sample_valid = 1'b0;
  logic a = 1'b0, b = 1'b0, c = 1'b0;

  logic [2:0] ready_v, busy_v, done_v, pass_v, fail_v;
  logic [7:0] err0, err1;
  logic [1:0] err2;
  logic [7:0] fidx0, fidx1, fidx2;
  logic [3:0] seen0, seen1, seen2;

  always #5 clk = ~clk;

  gate_resp_checker dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .sample_valid(sample_valid),
    .sample_ready(ready_v[0]), .a(a), .b(b), .c(c), .busy(busy_v[0]), .done(done_v[0]),
    .pass(pass_v[0]), .fail(fail_v[0]), .err_count(err0), .first_err_idx(fidx0), .seen_mask(seen0)
  );

  gate_resp_checker #(.REQUIRE_COV(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .sample_valid(sample_valid),
    .sample_ready(ready_v[1]), .a(a), .b(b), .c(c), .busy(busy_v[1]), .done(done_v[1]),
    .pass(pass_v[1]), .fail(fail_v[1]), .err_count(err1), .first_err_idx(fidx1), .seen_mask(seen1)
  );

  gate_resp_checker #(.ERR_W(2), .NUM_SAMPLES(6)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .sample_valid(sample_valid),
    .sample_ready(ready_v[2]), .a(a), .b(b), .c(c), .busy(busy_v[2]), .done(done_v[2]),
    .pass(pass_v[2]), .fail(fail_v[2]), .err_count(err2), .first_err_idx(fidx2), .seen_mask(seen2)
  );

  typedef struct {
    int         n_acc;
    bit         pass;
    int         err;
    int         fidx;
    logic [3:0] seen;
  } exp_t;

  exp_t       exp_q[$];
  logic [2:0] vec_q[$];
  bit         gap_q[$];
  int         checks = 0;
  int         errors = 0;

  function automatic int err_of(input int s);
    case (s)
      0: return int'(err0);
      1: return int'(err1);
      default: return int'(err2);
    endcase
  endfunction

  function automatic int fidx_of(input int s);
    case (s)
      0: return int'(fidx0);
      1: return int'(fidx1);
      default: return int'(fidx2);
    endcase
  endfunction

  function automatic logic [3:0] seen_of(input int s);
    case (s)
      0: return seen0;
      1: return seen1;
      default: return seen2;
    endcase
  endfunction

  // Reference model: expected outcome of a run over vec_q for instance s.
  function automatic exp_t model(input int s);
    exp_t e;
    int num, emax, rc;
    bit abort_en;
    logic [3:0] tt;
    logic [1:0] ab;
    bit mm;
    tt = TT;
    num  = (s == 2) ? 6 : 4;
    emax = (s == 2) ? 3 : 255;
    rc   = (s == 1) ? 0 : 1;
`ifdef GATE_RESP_CHECKER_ABORT_EN
    abort_en = 1'b1;
`else
    abort_en = 1'b0;
`endif
    e.n_acc = 0; e.err = 0; e.fidx = 0; e.seen = 4'h0;
    for (int i = 0; i < num; i++) begin
      ab = {vec_q[i][2], vec_q[i][1]};
      mm = (vec_q[i][0] != tt[ab]);
      e.seen[ab] = 1'b1;
      e.n_acc++;
      if (mm) begin
        if (e.err == 0) e.fidx = i;
        if (e.err < emax) e.err++;
        if (abort_en) break;
      end
    end
    e.pass = (e.err == 0) && ((rc == 0) || (e.seen == 4'hF));
    return e;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    start_v = 3'b000;
    sample_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++;
    if ({ready_v[0], busy_v[0], done_v[0], pass_v[0], fail_v[0]} !== 5'b0 ||
        err0 !== 8'd0 || fidx0 !== 8'd0 || seen0 !== 4'h0) begin
      errors++;
      $display("FAIL %s: rdy/busy/done/pass/fail=%b%b%b%b%b err=%0d fidx=%0d seen=%h, required all 0",
               tag, ready_v[0], busy_v[0], done_v[0], pass_v[0], fail_v[0], err0, fidx0, seen0);
    end
  endtask

  // Starts instance s, feeds vec_q (gated by gap_q), checks done timing, then scores the result.
  task automatic run_samples(input int s, input string name);
    exp_t e;
    int k, gi, accepts;
    bit rdy, seen_done;
    e = model(s);
    exp_q.push_back(e);
    k = 0; gi = 0; accepts = 0; seen_done = 1'b0;
    @(negedge clk);
    start_v[s] = 1'b1;
    @(negedge clk);
    start_v[s] = 1'b0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      checks++;
      if (done_v[s] !== (accepts == e.n_acc)) begin
        errors++;
        $display("FAIL %s done_timing: done=%b after %0d accepts, required %b",
                 name, done_v[s], accepts, (accepts == e.n_acc));
      end
      if (done_v[s] === 1'b1) begin
        seen_done = 1'b1;
        break;
      end
      sample_valid = (gi < gap_q.size()) ? gap_q[gi] : 1'b1;
      if (k < vec_q.size()) {a, b, c} = vec_q[k];
      rdy = ready_v[s];
      @(posedge clk);
      if (sample_valid && rdy) begin
        accepts++;
        k++;
      end
      gi++;
      @(negedge clk);
    end
    if (!seen_done) begin
      errors++;
      $display("FAIL %s timeout: done never rose after %0d accepts", name, accepts);
    end
    // Valid stays high in DONE; nothing may change.
    sample_valid = 1'b1;
    repeat (2) @(negedge clk);
    sample_valid = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (accepts != e.n_acc) begin
      errors++;
      $display("FAIL %s accepts: got %0d, required %0d", name, accepts, e.n_acc);
    end
    checks++;
    if (pass_v[s] !== e.pass || fail_v[s] !== !e.pass || done_v[s] !== 1'b1) begin
      errors++;
      $display("FAIL %s verdict: done=%b pass=%b fail=%b, required done=1 pass=%b fail=%b",
               name, done_v[s], pass_v[s], fail_v[s], e.pass, !e.pass);
    end
    checks++;
    if (err_of(s) != e.err) begin
      errors++;
      $display("FAIL %s err_count: got %0d, required %0d", name, err_of(s), e.err);
    end
    if (e.err != 0) begin
      checks++;
      if (fidx_of(s) != e.fidx) begin
        errors++;
        $display("FAIL %s first_err_idx: got %0d, required %0d", name, fidx_of(s), e.fidx);
      end
    end
    checks++;
    if (seen_of(s) !== e.seen) begin
      errors++;
      $display("FAIL %s seen_mask: got %h, required %h", name, seen_of(s), e.seen);
    end
    checks++;
    if (ready_v[s] !== 1'b0 || busy_v[s] !== 1'b0) begin
      errors++;
      $display("FAIL %s done_handshake: ready=%b busy=%b, required 0 0", name, ready_v[s], busy_v[s]);
    end
    $display("run %s: accepts=%0d pass=%b err=%0d fidx=%0d seen=%h",
             name, accepts, pass_v[s], err_of(s), fidx_of(s), seen_of(s));
  endtask

  task automatic load_impl();
    vec_q = '{3'b111, 3'b100, 3'b011, 3'b001};
    gap_q = {};
  endtask

  task automatic test_reset();
    do_reset();
    check_idle_outputs("reset");
  endtask

  task automatic test_back_to_back();
    load_impl();
    run_samples(0, "impl");
  endtask

  task automatic test_single_fault();
    vec_q = '{3'b111, 3'b101, 3'b011, 3'b001};
    gap_q = {};
    run_samples(0, "single_fault");
  endtask

  task automatic test_coverage_hole();
    vec_q = '{3'b111, 3'b111, 3'b001, 3'b001};
    gap_q = {};
    run_samples(0, "cov_hole_req");
    run_samples(1, "cov_hole_noreq");
  endtask

  task automatic test_gaps();
    load_impl();
    gap_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    run_samples(0, "gaps");
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    sample_valid = 1'b1;
    {a, b, c} = 3'b101;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("reset_mid_run");
    sample_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    load_impl();
    run_samples(0, "after_reset");
  endtask

  task automatic test_saturation();
    vec_q = '{3'b000, 3'b010, 3'b101, 3'b110, 3'b000, 3'b010};
    gap_q = {};
    run_samples(2, "saturation");
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_single_fault();
    test_coverage_hole();
    test_gaps();
    test_reset_mid_run();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
